matrix_dsp_sequencer: RTL and testbench
=======================================

MATRIX_DSP_SEQUENCER -- requirements
Module: MatrixDSPSequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, microcode address width; it matches the microcode ROM addr port.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, program launch request; sampled only in IDLE.
REQ-005 SHALL have port startAddr, input, ADDR_WIDTH, first microcode address; latched on accepted start.
REQ-006 SHALL have port length, input, ADDR_WIDTH, number of instructions per pass; latched on accepted start.
REQ-007 SHALL have port repeatCount, input, 8, extra passes; total passes = repeatCount+1; latched on accepted start.
REQ-008 SHALL have port stall, input, 1, downstream hold; no issue in a stall cycle.
REQ-009 SHALL have port abort, input, 1, terminate immediately.
REQ-010 SHALL have port addr, output, ADDR_WIDTH, registered program counter; drives ROM addr.
REQ-011 SHALL have port enable, output, 1, ROM read enable; one instruction issued per high cycle.
REQ-012 SHALL have port instrValid, output, 1, new ROM output word present this cycle.
REQ-013 SHALL have port lastInstr, output, 1, current valid word is the final one of the program.
REQ-014 SHALL have port busy, output, 1, high in RUN and DRAIN.
REQ-015 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN.
REQ-017 IDLE: on start=1 and abort=0, SHALL latch inputs, load addr=startAddr, and go to RUN; if length=0, SHALL go to DRAIN without issuing (done pulse, instrValid=0).
REQ-018 RUN: enable SHALL equal !stall && !abort, combinationally; in RUN no other state gates it.
REQ-019 On each issue (enable=1), addr SHALL advance by 1 modulo 2^ADDR_WIDTH, wrapping 0xFF->0x00.
REQ-020 After the length-th issue of a pass, if passes remain, addr SHALL reload startAddr and the pass counter SHALL decrement; no bubble is inserted between passes.
REQ-021 After the final issue of the final pass, SHALL go to DRAIN.
REQ-022 instrValid SHALL be enable registered by one cycle, matching the ROM's one-cycle read latency.
REQ-023 lastInstr SHALL be high only alongside the instrValid of the final issued word.
REQ-024 DRAIN SHALL last exactly one cycle with done=1, then return to IDLE; busy SHALL drop in the IDLE cycle.
REQ-025 stall SHALL freeze addr and all counters; a stall held for N cycles delays completion by exactly N cycles.
REQ-026 abort in RUN or DRAIN SHALL force enable=0 that cycle and IDLE next cycle; done, instrValid and lastInstr SHALL be 0 the next cycle.
REQ-027 abort SHALL win over stall and over start in the same cycle.
REQ-028 start while busy SHALL be ignored and have no effect on the latched values.

Reset
REQ-029 reset SHALL force IDLE, addr=0, counters=0, instrValid=0, lastInstr=0, done=0 and busy=0 at the next edge; enable SHALL be 0 while reset is high.
REQ-030 reset mid-program SHALL discard the program with no done pulse; reset overrides abort, start and stall.

Structure
REQ-031 SHALL place the state encoding (IDLE/RUN/DRAIN) and the ADDR_WIDTH default in the shared package MatrixDSPPkg.
REQ-032 SHALL be a single module; counters are inline and no sub-module is needed.
REQ-033 SHALL instantiate no memory; it connects directly to the MatrixDSP microcode ROM addr/enable ports.

Verification
REQ-034 start, startAddr=0x10, length=4, repeatCount=0 -> addr 0x10..0x13 issued on 4 consecutive cycles; instrValid one cycle later; lastInstr with the 4th word; done 1 cycle after the last issue.
REQ-035 startAddr=0xFE, length=3, repeatCount=1 -> issue sequence FE,FF,00,FE,FF,00 with no gaps; a single done pulse.
REQ-036 length=4, stall high for 3 cycles after the 2nd issue -> addr held; enable=0 for exactly 3 cycles; done 3 cycles later than in REQ-034.
REQ-037 abort asserted together with stall on the 3rd issue cycle -> enable=0 that cycle; IDLE next cycle; no done pulse; a fresh start is then accepted.
REQ-038 length=0 -> no enable; done one cycle after start; start pulsed while busy in REQ-034 -> ignored; reset mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/matrix_dsp_sequencer_pkg.sv
// Shared definitions for the MatrixDSP microcode sequencer: state encoding and
// the default microcode address width.
package matrix_dsp_sequencer_pkg;

  localparam int ADDR_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

endpackage

// File: rtl/matrix_dsp_sequencer.sv
// Microcode sequencer: walks a program of `length` words from `startAddr`,
// repeated repeatCount+1 times, driving the MatrixDSP microcode ROM directly.
module matrix_dsp_sequencer
  import matrix_dsp_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] startAddr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic [7:0]            repeatCount,
  input  logic                  stall,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  enable,
  output logic                  instrValid,
  output logic                  lastInstr,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] start_addr_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [7:0]            rep_q;
  logic                  vld_p1;
  logic                  last_p1;

  logic                  accept;
  logic                  issue;
  logic                  pass_end;
  logic                  prog_end;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    issue    = 1'b0;
    pass_end = 1'b0;
    prog_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          accept  = 1'b1;
          state_d = (length == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        issue    = !stall && !abort;
        pass_end = issue && (cnt_q == len_q - ONE);
        prog_end = pass_end && (rep_q == 8'd0);
        if (abort)
          state_d = ST_IDLE;
        else if (prog_end)
          state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Stage p0 -> p1: program counter advance and ROM-latency-matched valid/last
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      start_addr_q <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      rep_q        <= 8'd0;
      vld_p1       <= 1'b0;
      last_p1      <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= issue;
      last_p1 <= prog_end;
      if (accept) begin
        start_addr_q <= startAddr;
        len_q        <= length;
        rep_q        <= repeatCount;
        cnt_q        <= '0;
        addr_q       <= startAddr;
      end else if (issue) begin
        if (pass_end) begin
          cnt_q <= '0;
          // Reload on the same edge as the last issue so passes run back to back
          if (rep_q != 8'd0) begin
            addr_q <= start_addr_q;
            rep_q  <= rep_q - 8'd1;
          end else begin
            addr_q <= addr_q + ONE;
          end
        end else begin
          addr_q <= addr_q + ONE;
          cnt_q  <= cnt_q + ONE;
        end
      end
    end
  end

  assign addr       = addr_q;
  assign enable     = issue && !reset;
  assign instrValid = vld_p1;
  assign lastInstr  = last_p1;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_matrix_dsp_sequencer.sv
// Scoreboard bench for matrix_dsp_sequencer: expected issue words are queued
// when a program is launched and popped as the sequencer issues them.
module tb_matrix_dsp_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] startAddr;
  logic [7:0] length;
  logic [7:0] repeatCount;
  logic       stall;
  logic       abort;
  logic [7:0] addr;
  logic       enable;
  logic       instrValid;
  logic       lastInstr;
  logic       busy;
  logic       done;

  matrix_dsp_sequencer #(.ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .startAddr  (startAddr),
    .length     (length),
    .repeatCount(repeatCount),
    .stall      (stall),
    .abort      (abort),
    .addr       (addr),
    .enable     (enable),
    .instrValid (instrValid),
    .lastInstr  (lastInstr),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic       last;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int stall_cnt = 0;
  int issued = 0;
  bit mon_en = 1'b0;
  bit pend_vld = 1'b0;
  bit pend_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      chk("instrValid", 32'(instrValid), 32'(pend_vld));
      chk("lastInstr", 32'(lastInstr), 32'(pend_last));
      pend_vld  = 1'b0;
      pend_last = 1'b0;
      if (enable) begin
        if (exp_q.size() == 0) begin
          chk("spurious_issue", 32'(enable), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("issue_addr", 32'(addr), 32'(e.a));
          pend_vld  = 1'b1;
          pend_last = e.last;
          issued++;
        end
      end
      if (busy && !done && !enable) stall_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc_n;
      end
    end
  end

  task automatic push_prog(input logic [7:0] sa, input logic [7:0] len, input logic [7:0] rep);
    exp_t e;
    for (int p = 0; p <= int'(rep); p++) begin
      for (int i = 0; i < int'(len); i++) begin
        e.a    = sa + 8'(i);
        e.last = (p == int'(rep)) && (i == int'(len) - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_prog(input logic [7:0] sa, input logic [7:0] len, input logic [7:0] rep,
                          input int stall_after, input int stall_n, input bit poke_busy);
    int  k;
    int  d0;
    int  s0;
    int  t;
    bit  stalled;
    push_prog(sa, len, rep);
    k      = cyc_n;
    d0     = done_cnt;
    s0     = stall_cnt;
    issued = 0;
    startAddr   = sa;
    length      = len;
    repeatCount = rep;
    start       = 1'b1;
    tick();
    start   = 1'b0;
    stalled = 1'b0;
    t       = 0;
    while (done_cnt == d0 && t < 400) begin
      if (poke_busy && t == 1) begin
        start       = 1'b1;
        startAddr   = 8'h80;
        length      = 8'd7;
        repeatCount = 8'd3;
      end else begin
        start = 1'b0;
      end
      if (!stalled && stall_n > 0 && issued == stall_after) begin
        stall = 1'b1;
        repeat (stall_n) tick();
        stall   = 1'b0;
        stalled = 1'b1;
      end else begin
        tick();
      end
      t++;
    end
    start = 1'b0;
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("done_cycle", 32'(done_cyc), 32'(k + int'(len) * (int'(rep) + 1) + stall_n + 1));
    chk("stall_cycles", 32'(stall_cnt - s0), 32'(stall_n));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_after_done", 32'(done), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; startAddr = 8'h00; length = 8'h00;
    repeatCount = 8'h00; stall = 1'b0; abort = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_instrValid", 32'(instrValid), 32'd0);
    chk("rst_lastInstr", 32'(lastInstr), 32'd0);
    reset = 1'b0;
    tick();

    // basic 4-word program, with a start poked while busy
    run_prog(8'h10, 8'd4, 8'd0, 0, 0, 1'b1);
    tick();
    // wrap across 0xFF with one repeat pass, no gaps
    run_prog(8'hFE, 8'd3, 8'd1, 0, 0, 1'b0);
    tick();
    // 3-cycle stall after the second issue
    run_prog(8'h10, 8'd4, 8'd0, 2, 3, 1'b0);
    tick();
    // zero-length program
    run_prog(8'h40, 8'd0, 8'd0, 0, 0, 1'b0);
    tick();

    // abort with stall (and start) on the third issue cycle
    push_prog(8'h20, 8'd4, 8'd0);
    d0 = done_cnt;
    startAddr = 8'h20; length = 8'd4; repeatCount = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1; stall = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("abort_enable", 32'(enable), 32'd0);
    tick();
    abort = 1'b0; stall = 1'b0; start = 1'b0;
    exp_q.delete();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_instrValid", 32'(instrValid), 32'd0);
    chk("abort_lastInstr", 32'(lastInstr), 32'd0);
    tick();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // fresh start after abort
    run_prog(8'h30, 8'd2, 8'd2, 0, 0, 1'b0);
    tick();

    // reset mid-program
    push_prog(8'h50, 8'd8, 8'd0);
    d0 = done_cnt;
    startAddr = 8'h50; length = 8'd8; repeatCount = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1; abort = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rst_mid_enable", 32'(enable), 32'd0);
    tick();
    reset = 1'b0; abort = 1'b0; start = 1'b0;
    exp_q.delete();
    chk("rst_mid_addr", 32'(addr), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_instrValid", 32'(instrValid), 32'd0);
    chk("rst_mid_lastInstr", 32'(lastInstr), 32'd0);
    tick();
    tick();
    chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
